// File: rtl/uart_event_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_event_scheduler
// Description : Round-robin arbiter that frames events from three requesters
//               as HDR/CODE[/CKSUM] byte sequences for a UART transmitter.
//               The CKSUM byte is built only with UART_SCHED_CKSUM_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_event_scheduler #(
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_evt_req,
    input  logic [7:0] i_evt_code0,
    input  logic [7:0] i_evt_code1,
    input  logic [7:0] i_evt_code2,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    output logic [2:0] o_grant,
    output logic [2:0] o_pending,
    output logic       o_busy,
    output logic [7:0] o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_CODE  = 2'd2,
        S_CKSUM = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_code [3];
    logic [7:0] w_evt_code [3];
    logic [2:0] r_pending;
    logic [2:0] r_grant;
    logic [1:0] r_last;
    logic [7:0] r_frame;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic [7:0] r_drop_cnt;

    logic [1:0] w_sel;
    logic       w_fire;
    logic [2:0] w_clr;
    logic [2:0] w_drop_vec;
    logic [1:0] w_drop_num;
    logic [8:0] w_drop_sum;
    logic       w_accept;

    assign w_evt_code[0] = i_evt_code0;
    assign w_evt_code[1] = i_evt_code1;
    assign w_evt_code[2] = i_evt_code2;

    // Search order starts at the requester after the last one granted
    always_comb begin
        w_sel = 2'd0;
        case (r_last)
            2'd0: begin
                if (r_pending[1])      w_sel = 2'd1;
                else if (r_pending[2]) w_sel = 2'd2;
                else                   w_sel = 2'd0;
            end
            2'd1: begin
                if (r_pending[2])      w_sel = 2'd2;
                else if (r_pending[0]) w_sel = 2'd0;
                else                   w_sel = 2'd1;
            end
            default: begin
                if (r_pending[0])      w_sel = 2'd0;
                else if (r_pending[1]) w_sel = 2'd1;
                else                   w_sel = 2'd2;
            end
        endcase
    end

    assign w_fire   = (r_state == S_IDLE) && (|r_pending);
    assign w_clr    = w_fire ? (3'b001 << w_sel) : 3'b000;
    assign w_accept = r_tx_valid & i_tx_ready;

    // A pulse onto the requester being granted this edge is a fresh event, not a drop
    assign w_drop_vec = i_evt_req & r_pending & ~w_clr;
    assign w_drop_num = {1'b0, w_drop_vec[0]} + {1'b0, w_drop_vec[1]} + {1'b0, w_drop_vec[2]};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_num};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending  <= 3'b000;
            r_drop_cnt <= 8'd0;
            for (int k = 0; k < 3; k++) begin
                r_code[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (i_evt_req[k]) begin
                    r_pending[k] <= 1'b1;
                    r_code[k]    <= w_evt_code[k];
                end else if (w_clr[k]) begin
                    r_pending[k] <= 1'b0;
                end
            end
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_grant    <= 3'b000;
            r_frame    <= 8'd0;
            r_last     <= 2'd2;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_frame    <= r_code[w_sel];
                        r_grant    <= w_clr;
                        r_last     <= w_sel;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= HDR_BYTE;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_accept) begin
                        r_tx_data <= r_frame;
                        r_state   <= S_CODE;
                    end
                end
                S_CODE: begin
                    if (w_accept) begin
`ifdef UART_SCHED_CKSUM_EN
                        r_tx_data <= HDR_BYTE ^ r_frame;
                        r_state   <= S_CKSUM;
`else
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'd0;
                        r_grant    <= 3'b000;
                        r_state    <= S_IDLE;
`endif
                    end
                end
                S_CKSUM: begin
`ifdef UART_SCHED_CKSUM_EN
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'd0;
                        r_grant    <= 3'b000;
                        r_state    <= S_IDLE;
                    end
`else
                    // Unreachable without the checksum byte; recover to idle
                    r_tx_valid <= 1'b0;
                    r_tx_data  <= 8'd0;
                    r_grant    <= 3'b000;
                    r_state    <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_grant    = r_grant;
    assign o_pending  = r_pending;
    assign o_busy     = (r_state != S_IDLE);
    assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_event_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_event_scheduler
// Description : Directed self-checking bench for uart_event_scheduler; follows
//               the UART_SCHED_CKSUM_EN setting for the expected frame length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_event_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] evt_req;
    logic [7:0] code0, code1, code2;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [2:0] grant;
    logic [2:0] pending;
    logic       busy;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UART_SCHED_CKSUM_EN
    localparam int FLEN = 3;
`else
    localparam int FLEN = 2;
`endif

    always #5 clk = ~clk;

    uart_event_scheduler #(.HDR_BYTE(8'hA5)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_evt_req   (evt_req),
        .i_evt_code0 (code0),
        .i_evt_code1 (code1),
        .i_evt_code2 (code2),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_grant     (grant),
        .o_pending   (pending),
        .o_busy      (busy),
        .o_drop_cnt  (drop_cnt)
    );

    function automatic logic [7:0] fbyte(input int b, input logic [7:0] c);
        if (b == 0)      return 8'hA5;
        else if (b == 1) return c;
        else             return 8'hA5 ^ c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        evt_req = 3'b000;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tx_ready = 1'b1;
        evt_req = 3'b111;
        code0 = 8'hFF; code1 = 8'hFF; code2 = 8'hFF;
        tick;
        tick;
        rst = 1'b0;
        evt_req = 3'b000;
        n_checks++;
        if ({tx_valid, tx_data, grant, pending, busy, drop_cnt} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_state got valid=%b data=%h grant=%b pend=%b busy=%b drop=%0d exp all zero",
                     tx_valid, tx_data, grant, pending, busy, drop_cnt);
        end
    endtask

    task automatic test_single;
        logic [7:0] c;
        c = (FLEN == 3) ? 8'h01 : 8'h0F;
        tx_ready = 1'b1;
        evt_req = 3'b001; code0 = c;
        tick;
        evt_req = 3'b000;
        n_checks++;
        if ({pending, grant, tx_valid} !== {3'b001, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_pend got pend=%b grant=%b valid=%b exp 001 000 0", pending, grant, tx_valid);
        end
        tick;
        n_checks++;
        if ({grant, pending, busy} !== {3'b001, 3'b000, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant got grant=%b pend=%b busy=%b exp 001 000 1", grant, pending, busy);
        end
        for (int b = 0; b < FLEN; b++) begin
            n_checks++;
            if ({tx_valid, tx_data, grant} !== {1'b1, fbyte(b, c), 3'b001}) begin
                n_fail++;
                $display("FAIL single_byte%0d got valid=%b data=%h grant=%b exp 1 %h 001",
                         b, tx_valid, tx_data, grant, fbyte(b, c));
            end
            tick;
        end
        n_checks++;
        if ({tx_valid, grant, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_end got valid=%b grant=%b busy=%b exp 0 000 0", tx_valid, grant, busy);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] codes [3];
        logic [2:0] exp_pend;
        codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33;
        do_reset;
        tx_ready = 1'b1;
        evt_req = 3'b111; code0 = codes[0]; code1 = codes[1]; code2 = codes[2];
        tick;
        evt_req = 3'b000;
        n_checks++;
        if (pending !== 3'b111) begin
            n_fail++;
            $display("FAIL rr_pend_all got %b exp 111", pending);
        end
        for (int f = 0; f < 3; f++) begin
            tick;
            exp_pend = 3'(3'b111 << (f + 1));
            n_checks++;
            if ({grant, pending} !== {3'(1 << f), exp_pend}) begin
                n_fail++;
                $display("FAIL rr_grant%0d got grant=%b pend=%b exp %b %b", f, grant, pending, 3'(1 << f), exp_pend);
            end
            for (int b = 0; b < FLEN; b++) begin
                n_checks++;
                if ({tx_valid, tx_data} !== {1'b1, fbyte(b, codes[f])}) begin
                    n_fail++;
                    $display("FAIL rr_f%0d_byte%0d got valid=%b data=%h exp 1 %h",
                             f, b, tx_valid, tx_data, fbyte(b, codes[f]));
                end
                tick;
            end
            n_checks++;
            if ({tx_valid, grant, busy} !== 5'b0) begin
                n_fail++;
                $display("FAIL rr_idle%0d got valid=%b grant=%b busy=%b exp 0 000 0", f, tx_valid, grant, busy);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        tx_ready = 1'b0;
        evt_req = 3'b001; code0 = 8'h5A;
        tick;
        evt_req = 3'b000;
        tick;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({tx_valid, tx_data, busy} !== {1'b1, 8'hA5, 1'b1}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got valid=%b data=%h busy=%b exp 1 a5 1", i, tx_valid, tx_data, busy);
            end
            tick;
        end
        tx_ready = 1'b1;
        for (int b = 0; b < FLEN; b++) begin
            n_checks++;
            if ({tx_valid, tx_data} !== {1'b1, fbyte(b, 8'h5A)}) begin
                n_fail++;
                $display("FAIL bp_byte%0d got valid=%b data=%h exp 1 %h", b, tx_valid, tx_data, fbyte(b, 8'h5A));
            end
            tick;
        end
        n_checks++;
        if ({tx_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_end got valid=%b busy=%b exp 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_drop;
        int guard;
        do_reset;
        tx_ready = 1'b1;
        evt_req = 3'b001; code0 = 8'h77;
        tick;
        evt_req = 3'b000;
        tick;
        evt_req = 3'b010; code1 = 8'h10;
        tick;
        evt_req = 3'b010; code1 = 8'h20;
        tick;
        evt_req = 3'b000;
        n_checks++;
        if ({drop_cnt, pending[1]} !== {8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL drop_count got drop=%0d pend1=%b exp 1 1", drop_cnt, pending[1]);
        end
        guard = 0;
        while (grant !== 3'b010 && guard < 10) begin
            tick;
            guard++;
        end
        n_checks++;
        if (grant !== 3'b010) begin
            n_fail++;
            $display("FAIL drop_wait_grant got grant=%b exp 010", grant);
        end
        for (int b = 0; b < FLEN; b++) begin
            n_checks++;
            if ({tx_valid, tx_data} !== {1'b1, fbyte(b, 8'h20)}) begin
                n_fail++;
                $display("FAIL drop_byte%0d got valid=%b data=%h exp 1 %h", b, tx_valid, tx_data, fbyte(b, 8'h20));
            end
            tick;
        end
        n_checks++;
        if ({tx_valid, drop_cnt} !== {1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL drop_end got valid=%b drop=%0d exp 0 1", tx_valid, drop_cnt);
        end
    endtask

    task automatic test_grant_edge_pulse;
        do_reset;
        tx_ready = 1'b1;
        evt_req = 3'b100; code2 = 8'h44;
        tick;
        evt_req = 3'b100; code2 = 8'h55;
        tick;
        evt_req = 3'b000;
        n_checks++;
        if ({grant, pending, drop_cnt} !== {3'b100, 3'b100, 8'd0}) begin
            n_fail++;
            $display("FAIL gep_grant got grant=%b pend=%b drop=%0d exp 100 100 0", grant, pending, drop_cnt);
        end
        for (int b = 0; b < FLEN; b++) begin
            n_checks++;
            if (tx_data !== fbyte(b, 8'h44)) begin
                n_fail++;
                $display("FAIL gep_f1_byte%0d got %h exp %h", b, tx_data, fbyte(b, 8'h44));
            end
            tick;
        end
        tick;
        n_checks++;
        if ({grant, pending} !== {3'b100, 3'b000}) begin
            n_fail++;
            $display("FAIL gep_regrant got grant=%b pend=%b exp 100 000", grant, pending);
        end
        for (int b = 0; b < FLEN; b++) begin
            n_checks++;
            if (tx_data !== fbyte(b, 8'h55)) begin
                n_fail++;
                $display("FAIL gep_f2_byte%0d got %h exp %h", b, tx_data, fbyte(b, 8'h55));
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_frame;
        do_reset;
        tx_ready = 1'b1;
        evt_req = 3'b001; code0 = 8'h66;
        tick;
        evt_req = 3'b000;
        tick;
        evt_req = 3'b010; code1 = 8'h01;
        tick;
        tx_ready = 1'b0;
        evt_req = 3'b010; code1 = 8'h02;
        tick;
        evt_req = 3'b000;
        n_checks++;
        if ({tx_valid, tx_data, pending, drop_cnt} !== {1'b1, 8'h66, 3'b010, 8'd1}) begin
            n_fail++;
            $display("FAIL rmf_pre got valid=%b data=%h pend=%b drop=%0d exp 1 66 010 1",
                     tx_valid, tx_data, pending, drop_cnt);
        end
        rst = 1'b1;
        evt_req = 3'b100;
        tick;
        rst = 1'b0;
        evt_req = 3'b000;
        n_checks++;
        if ({tx_valid, pending, drop_cnt, grant, busy} !== 16'd0) begin
            n_fail++;
            $display("FAIL rmf_abort got valid=%b pend=%b drop=%0d grant=%b busy=%b exp all zero",
                     tx_valid, pending, drop_cnt, grant, busy);
        end
        tx_ready = 1'b1;
        evt_req = 3'b100; code2 = 8'h3C;
        tick;
        evt_req = 3'b000;
        tick;
        n_checks++;
        if (grant !== 3'b100) begin
            n_fail++;
            $display("FAIL rmf_grant got %b exp 100", grant);
        end
        for (int b = 0; b < FLEN; b++) begin
            n_checks++;
            if ({tx_valid, tx_data} !== {1'b1, fbyte(b, 8'h3C)}) begin
                n_fail++;
                $display("FAIL rmf_byte%0d got valid=%b data=%h exp 1 %h", b, tx_valid, tx_data, fbyte(b, 8'h3C));
            end
            tick;
        end
        n_checks++;
        if ({tx_valid, busy, grant} !== 5'b0) begin
            n_fail++;
            $display("FAIL rmf_end got valid=%b busy=%b grant=%b exp 0 0 000", tx_valid, busy, grant);
        end
    endtask

    initial begin
        rst = 1'b1;
        evt_req = 3'b000;
        code0 = 8'd0; code1 = 8'd0; code2 = 8'd0;
        tx_ready = 1'b1;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_drop;
        test_grant_edge_pulse;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
